alu_operand_regfile: RTL and testbench

- Register file at the other end of the ALU datapath: supplies the two ALU operands (DATA1/DATA2 side) and captures the ALU RESULT and ZERO on write-back.
- 8 x 8-bit registers, two asynchronous read ports, one synchronous write port, plus a registered ZERO flag for branch logic.
- Synchronous reset starts a sequential clear engine that zeroes one register per clock. Writes are blocked while the clear is in progress.

---
 rtl/alu_operand_regfile_pkg.sv | 22 ++
 rtl/alu_operand_regfile_if.sv | 28 ++
 rtl/alu_operand_regfile_reg_clear_fsm.sv | 32 +++
 rtl/alu_operand_regfile.sv | 52 +++++
 tb/tb_alu_operand_regfile.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_operand_regfile_pkg.sv
// Shared constants, state encoding and timing defaults for the ALU operand register file.
`timescale 1ns/1ps
package alu_operand_regfile_pkg;

  localparam int NUM_REGS = 8;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;

  // Simulation timing shared with the ALU model; the RTL itself is zero-delay.
  localparam int READ_DELAY  = 2;
  localparam int WRITE_DELAY = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  function automatic logic is_last_reg(input logic [ADDR_W-1:0] ptr);
    return ptr == ADDR_W'(NUM_REGS - 1);
  endfunction

endpackage

// File: rtl/alu_operand_regfile_if.sv
// Write-back, flag and read-port signals between the datapath and the register file.
`timescale 1ns/1ps
interface alu_operand_regfile_if #(
  parameter int DATA_W = alu_operand_regfile_pkg::DATA_W,
  parameter int ADDR_W = alu_operand_regfile_pkg::ADDR_W
);
  logic              WRITEENABLE;
  logic [ADDR_W-1:0] WRITEREG;
  logic [DATA_W-1:0] IN;
  logic              ZERO_IN;
  logic              FLAG_WE;
  logic [ADDR_W-1:0] OUT1ADDRESS;
  logic [ADDR_W-1:0] OUT2ADDRESS;
  logic [DATA_W-1:0] OUT1;
  logic [DATA_W-1:0] OUT2;
  logic              ZERO_FLAG;
  logic              BUSY;

  modport master (
    output WRITEENABLE, WRITEREG, IN, ZERO_IN, FLAG_WE, OUT1ADDRESS, OUT2ADDRESS,
    input  OUT1, OUT2, ZERO_FLAG, BUSY
  );

  modport slave (
    input  WRITEENABLE, WRITEREG, IN, ZERO_IN, FLAG_WE, OUT1ADDRESS, OUT2ADDRESS,
    output OUT1, OUT2, ZERO_FLAG, BUSY
  );
endinterface

// File: rtl/alu_operand_regfile_reg_clear_fsm.sv
// Sequential clear engine: after reset, walks clear_ptr over every register, one per clock.
`timescale 1ns/1ps
module reg_clear_fsm
  import alu_operand_regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  output logic              clear_en,
  output logic [ADDR_W-1:0] clear_ptr,
  output logic              BUSY
);

  state_t state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= CLEAR;
      clear_ptr <= '0;
      BUSY      <= 1'b1;
    end else if (state == CLEAR) begin
      clear_ptr <= clear_ptr + 1'b1;
      if (is_last_reg(clear_ptr)) begin
        state <= READY;
        BUSY  <= 1'b0;
      end
    end
  end

  // A held reset keeps the pointer parked and clears nothing.
  assign clear_en = (state == CLEAR) && !RESET;

endmodule

// File: rtl/alu_operand_regfile.sv
// 8x8 register file feeding ALU DATA1/DATA2, capturing RESULT on write-back and ZERO for branches.
`timescale 1ns/1ps
module alu_operand_regfile
  import alu_operand_regfile_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  alu_operand_regfile_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              clear_en;
  logic [ADDR_W-1:0] clear_ptr;
  logic              busy;
  logic              write_en;
  logic              flag_en;
  logic              zero_flag;

  reg_clear_fsm u_clear (
    .CLK       (CLK),
    .RESET     (RESET),
    .clear_en  (clear_en),
    .clear_ptr (clear_ptr),
    .BUSY      (busy)
  );

  // Reset dominates: an edge with RESET high performs neither a write nor a flag capture.
  assign write_en = bus.WRITEENABLE && !busy && !RESET;
  assign flag_en  = bus.FLAG_WE     && !busy && !RESET;

  always_ff @(posedge CLK) begin
    if (clear_en) begin
      regs[clear_ptr] <= '0;
    end else if (write_en) begin
      regs[bus.WRITEREG] <= bus.IN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      zero_flag <= 1'b0;
    end else if (flag_en) begin
      zero_flag <= bus.ZERO_IN;
    end
  end

  assign bus.OUT1      = busy ? '0 : regs[bus.OUT1ADDRESS];
  assign bus.OUT2      = busy ? '0 : regs[bus.OUT2ADDRESS];
  assign bus.ZERO_FLAG = zero_flag;
  assign bus.BUSY      = busy;

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Directed plus randomized bench for alu_operand_regfile against an array-based reference model.
`timescale 1ns/1ps
module tb_alu_operand_regfile;
  import alu_operand_regfile_pkg::*;

  logic CLK;
  logic RESET;
  alu_operand_regfile_if bus ();

  alu_operand_regfile dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic              m_busy;
  logic              m_zf;
  int                m_cnt;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DATA_W-1:0] e1, e2;
    e1 = m_busy ? '0 : m_regs[bus.OUT1ADDRESS];
    e2 = m_busy ? '0 : m_regs[bus.OUT2ADDRESS];
    chk({tag, ".out1"}, bus.OUT1, e1);
    chk({tag, ".out2"}, bus.OUT2, e2);
    chk({tag, ".busy"}, {7'd0, bus.BUSY}, {7'd0, m_busy});
    chk({tag, ".zflag"}, {7'd0, bus.ZERO_FLAG}, {7'd0, m_zf});
  endtask

  // Model the edge from the inputs currently applied, then advance the clock and compare.
  task automatic step(input string tag);
    if (RESET) begin
      m_busy = 1'b1;
      m_cnt  = 0;
      m_zf   = 1'b0;
    end else if (m_busy) begin
      m_regs[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == NUM_REGS) m_busy = 1'b0;
    end else begin
      if (bus.WRITEENABLE) m_regs[bus.WRITEREG] = bus.IN;
      if (bus.FLAG_WE) m_zf = bus.ZERO_IN;
    end
    @(posedge CLK);
    #(WRITE_DELAY + READ_DELAY);
    check_all(tag);
  endtask

  task automatic run_until_ready(input string tag, output int n);
    n = 0;
    while (bus.BUSY !== 1'b0 && n < 32) begin
      step(tag);
      n++;
    end
  endtask

  task automatic idle_inputs();
    bus.WRITEENABLE = 1'b0;
    bus.FLAG_WE     = 1'b0;
    bus.ZERO_IN     = 1'b0;
    bus.WRITEREG    = '0;
    bus.IN          = '0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_busy = 1'b1;
    m_zf   = 1'b0;
    m_cnt  = 0;
    RESET  = 1'b1;
    idle_inputs();
    bus.OUT1ADDRESS = '0;
    bus.OUT2ADDRESS = '0;

    // Reset held for two edges, then the clear must take exactly NUM_REGS edges.
    step("rst0");
    step("rst1");
    RESET = 1'b0;
    run_until_ready("clr", n);
    chk("clear_edges", 8'(n), 8'(NUM_REGS));

    for (int a = 0; a < NUM_REGS; a++) begin
      bus.OUT1ADDRESS = 3'(a);
      bus.OUT2ADDRESS = 3'(NUM_REGS - 1 - a);
      #1;
      check_all("zero_sweep");
      chk("zero_sweep.out1_const", bus.OUT1, 8'h00);
    end
    chk("zflag_after_reset", {7'd0, bus.ZERO_FLAG}, 8'h00);

    // Basic writes to reg3 and reg5.
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd3; bus.IN = 8'h2A;
    step("wr3");
    bus.WRITEREG = 3'd5; bus.IN = 8'h15;
    step("wr5");
    idle_inputs();
    bus.OUT1ADDRESS = 3'd3;
    bus.OUT2ADDRESS = 3'd5;
    #1;
    chk("rd3", bus.OUT1, 8'h2A);
    chk("rd5", bus.OUT2, 8'h15);

    // No bypass: reading reg2 during its write returns the old value until the edge.
    bus.OUT1ADDRESS = 3'd2;
    bus.OUT2ADDRESS = 3'd2;
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd2; bus.IN = 8'hFF;
    #1;
    chk("rd2_old", bus.OUT1, 8'h00);
    step("wr2");
    chk("rd2_new1", bus.OUT1, 8'hFF);
    chk("rd2_new2", bus.OUT2, 8'hFF);
    idle_inputs();

    // A write attempted during the clear is dropped.
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd7; bus.IN = 8'h77;
    step("wr7");
    idle_inputs();
    RESET = 1'b1;
    step("rst_fill");
    RESET = 1'b0;
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd7; bus.IN = 8'h11;
    step("wr7_drop");
    chk("busy_during_drop", {7'd0, bus.BUSY}, 8'h01);
    idle_inputs();
    run_until_ready("clr2", n);
    bus.OUT1ADDRESS = 3'd7;
    #1;
    chk("rd7_cleared", bus.OUT1, 8'h00);

    // Reset reasserted on the fourth clear edge restarts the full count.
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd4; bus.IN = 8'hA5;
    step("wr4");
    idle_inputs();
    RESET = 1'b1;
    step("rst_a");
    RESET = 1'b0;
    for (int k = 0; k < 3; k++) step("clr_part");
    RESET = 1'b1;
    step("rst_mid");
    RESET = 1'b0;
    run_until_ready("clr3", n);
    chk("restart_edges", 8'(n), 8'(NUM_REGS));

    // Flag capture, hold, and simultaneous flag plus register write.
    bus.FLAG_WE = 1'b1; bus.ZERO_IN = 1'b1;
    step("flag_set");
    chk("zflag_set", {7'd0, bus.ZERO_FLAG}, 8'h01);
    bus.FLAG_WE = 1'b0; bus.ZERO_IN = 1'b0;
    step("flag_hold");
    chk("zflag_hold", {7'd0, bus.ZERO_FLAG}, 8'h01);
    bus.FLAG_WE = 1'b1; bus.ZERO_IN = 1'b0;
    bus.WRITEENABLE = 1'b1; bus.WRITEREG = 3'd1; bus.IN = 8'h01;
    bus.OUT1ADDRESS = 3'd1;
    step("flag_wr");
    chk("zflag_clr", {7'd0, bus.ZERO_FLAG}, 8'h00);
    chk("rd1", bus.OUT1, 8'h01);
    idle_inputs();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      RESET           = ($urandom_range(0, 59) == 0);
      bus.WRITEENABLE = $urandom_range(0, 1);
      bus.FLAG_WE     = ($urandom_range(0, 3) == 0);
      bus.ZERO_IN     = $urandom_range(0, 1);
      bus.WRITEREG    = 3'($urandom_range(0, NUM_REGS - 1));
      bus.IN          = 8'($urandom);
      bus.OUT1ADDRESS = 3'($urandom_range(0, NUM_REGS - 1));
      bus.OUT2ADDRESS = 3'($urandom_range(0, NUM_REGS - 1));
      #1;
      check_all("rnd_pre");
      step("rnd");
    end
    RESET = 1'b0;
    idle_inputs();
    run_until_ready("rnd_tail", n);
    for (int a = 0; a < NUM_REGS; a++) begin
      bus.OUT1ADDRESS = 3'(a);
      #1;
      check_all("final_sweep");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
